// File: rtl/lot_occupancy_counter.sv
// rtl/lot_occupancy_counter.sv - multi-lane parking-lot occupancy counter with clamping and sticky errors (optional LOT_STATS_EN)
module lot_occupancy_counter #(
    parameter int CAPACITY    = 15,
    parameter int NUM_ENTRY   = 2,
    parameter int NUM_EXIT    = 2,
    parameter int ALMOST_FULL = 12,
    localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ENTRY-1:0] inc,
    input  logic [NUM_EXIT-1:0]  dec,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 err_ovf,
    output logic                 err_unf,
`ifdef LOT_STATS_EN
    output logic [15:0]          total_in,
    output logic [15:0]          total_out,
`endif
    output logic                 err
);

    localparam int IN_W  = $clog2(NUM_ENTRY + 1);
    localparam int OUT_W = $clog2(NUM_EXIT + 1);
    // Wide enough that count + all entries - all exits can never wrap.
    localparam int SUM_W = CNT_W + IN_W + OUT_W + 2;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    if (CAPACITY < 1 || NUM_ENTRY < 1 || NUM_EXIT < 1 ||
        ALMOST_FULL < 0 || ALMOST_FULL > CAPACITY) begin : g_bad_params
        $error("lot_occupancy_counter: illegal parameter combination");
    end

    logic [IN_W-1:0]         n_in;
    logic [OUT_W-1:0]        n_out;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;
    logic                    unf;
    logic [CNT_W-1:0]        next_count;

    // Count lane pulses and net entries against exits, clamping to [0, CAPACITY].
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            n_in = n_in + IN_W'(inc[i]);
        end
        for (int j = 0; j < NUM_EXIT; j++) begin
            n_out = n_out + OUT_W'(dec[j]);
        end
        sum = SUM_W'(count) + SUM_W'(n_in) - SUM_W'(n_out);
        ovf = (sum > CAP_S);
        unf = sum[SUM_W-1];
        if (ovf) begin
            next_count = CNT_W'(CAPACITY);
        end else if (unf) begin
            next_count = '0;
        end else begin
            next_count = sum[CNT_W-1:0];
        end
    end

    // Occupancy register and sticky error flags; a fresh clamp beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            count   <= next_count;
            err_ovf <= ovf | (err_ovf & ~err_clr);
            err_unf <= unf | (err_unf & ~err_clr);
        end
    end

`ifdef LOT_STATS_EN
    logic [SUM_W-1:0]   admitted;
    logic [SUM_W-1:0]   released;
    logic [SUM_W+16:0]  tin_sum;
    logic [SUM_W+16:0]  tout_sum;

    // Cars actually admitted/released after clamping, added with 16-bit saturation.
    always_comb begin
        admitted = ovf ? (SUM_W'(CAPACITY) - SUM_W'(count) + SUM_W'(n_out)) : SUM_W'(n_in);
        released = unf ? (SUM_W'(count) + SUM_W'(n_in)) : SUM_W'(n_out);
        tin_sum  = (SUM_W + 17)'(total_in) + (SUM_W + 17)'(admitted);
        tout_sum = (SUM_W + 17)'(total_out) + (SUM_W + 17)'(released);
    end

    // Lifetime traffic totals; unaffected by err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_in  <= '0;
            total_out <= '0;
        end else begin
            total_in  <= (tin_sum  > (SUM_W + 17)'(16'hFFFF)) ? 16'hFFFF : tin_sum[15:0];
            total_out <= (tout_sum > (SUM_W + 17)'(16'hFFFF)) ? 16'hFFFF : tout_sum[15:0];
        end
    end
`endif

    assign full        = (count == CNT_W'(CAPACITY));
    assign empty       = (count == '0);
    assign almost_full = ({1'b0, count} >= (CNT_W + 1)'(ALMOST_FULL));
    assign err         = err_ovf | err_unf;

endmodule
